// File: rtl/register_file_zero.sv
// MIPS-style register file: entry 0 hardwired to zero, combinational reads with
// same-cycle write bypass, and a pending-write scoreboard for RAW hazard detection.
module register_file_zero #(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 32,
    parameter  int NUM_RD = 2,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    issue_en,
    input  logic [AW-1:0]           issue_addr,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_pending,
    output logic                    any_pending
);

    logic [WIDTH-1:0] regs [1:DEPTH-1];
    logic [DEPTH-1:1] pending_q;
    logic [DEPTH-1:0] pending_vec;

    logic wr_fire;
    logic issue_fire;

    assign wr_fire    = reset_n && wr_en && (wr_addr != '0);
    assign issue_fire = reset_n && issue_en && (issue_addr != '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    // NOTE: the storage array is reset too; an un-reset memory would let reads
    // return X after reset, which the outputs must never do.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_fire) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // A newly issued writer outranks the older write completing on the same entry.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (issue_fire && (issue_addr == AW'(i))) begin
                    pending_q[i] <= 1'b1;
                end else if (wr_fire && (wr_addr == AW'(i))) begin
                    pending_q[i] <= 1'b0;
                end
            end
        end
    end

    assign pending_vec = {pending_q, 1'b0};
    assign any_pending = |pending_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          is_zero;
        logic          bypass;

        assign addr    = rd_addr[k*AW +: AW];
        assign is_zero = (addr == '0);
        assign bypass  = reset_n && wr_en && (wr_addr == addr);

        assign rd_data[k*WIDTH +: WIDTH] = is_zero ? '0
                                         : bypass  ? wr_data
                                         :           regs[addr];
        assign rd_pending[k] = !is_zero && !bypass && pending_vec[addr];
    end

endmodule
